// File: rtl/mbus_requester.sv
// MBUS port-A requester: issues one quadword read or write cycle per command to an
// MB20 memory and reports ACKN/data timeouts and read-parity errors.
module mbus_requester #(
    parameter int ACK_TIMEOUT  = 64,
    parameter int DATA_TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         reset_l_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic         cmd_write_i,
    input  logic [21:0]  cmd_adr_i,
    input  logic [3:0]   cmd_mask_i,
    input  logic [143:0] cmd_wdata_i,
    output logic         rsp_valid_o,
    output logic [1:0]   rsp_word_o,
    output logic [35:0]  rsp_data_o,
    output logic         rsp_par_err_o,
    output logic         done_o,
    output logic         err_timeout_o,
    output logic         mbus_clk_o,
    output logic         mbus_start_a_o,
    output logic         mbus_start_b_o,
    output logic         mbus_rd_rq_o,
    output logic         mbus_wr_rq_o,
    output logic [3:0]   mbus_rq_o,
    output logic [21:0]  mbus_adr_o,
    output logic         mbus_adr_par_o,
    output logic [35:0]  mbus_d_out_o,
    output logic         mbus_par_out_o,
    output logic         mbus_valid_out_a_o,
    output logic         mbus_valid_out_b_o,
    output logic         mbus_adr_hold_o,
    output logic         mbus_mem_reset_o,
    output logic         mbus_diag_o,
    input  logic         mbus_ackn_a_i,
    input  logic         mbus_valid_in_a_i,
    input  logic [35:0]  mbus_d_in_i,
    input  logic         mbus_par_in_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RDATA = 3'd2,
        S_WDATA = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam int TMAX = (ACK_TIMEOUT > DATA_TIMEOUT) ? ACK_TIMEOUT : DATA_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] DATA_LAST = TW'(DATA_TIMEOUT - 1);

    function automatic logic odd_par36(input logic [35:0] d);
        return ~^d;
    endfunction

    function automatic logic odd_par22(input logic [21:0] d);
        return ~^d;
    endfunction

    function automatic logic [2:0] popcnt4(input logic [3:0] m);
        return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
    endfunction

    // Mask and data use KL10 numbering: word 0 is rq[0], the MSB of the vector.
    function automatic logic in_mask(input logic [3:0] m, input logic [1:0] w);
        return m[2'd3 - w];
    endfunction

    function automatic logic [1:0] next_set(input logic [3:0] m, input logic [1:0] from,
                                            input logic incl);
        logic [1:0] idx;
        logic       found;
        next_set = from;
        found    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = from + 2'(i) + {1'b0, ~incl};
            if (!found && in_mask(m, idx)) begin
                next_set = idx;
                found    = 1'b1;
            end
        end
    endfunction

    function automatic logic [35:0] word_sel(input logic [143:0] wd, input logic [1:0] w);
        case (w)
            2'd0:    return wd[143:108];
            2'd1:    return wd[107:72];
            2'd2:    return wd[71:36];
            2'd3:    return wd[35:0];
            default: return 36'd0;
        endcase
    endfunction

    state_e         state_q;
    logic           cmd_ready_q, write_q;
    logic [3:0]     mask_q;
    logic [143:0]   wdata_q;
    logic [1:0]     word_q;
    logic [2:0]     cnt_q;
    logic [TW-1:0]  timer_q;
    logic           rsp_valid_q, rsp_par_err_q, done_q, err_timeout_q;
    logic [1:0]     rsp_word_q;
    logic [35:0]    rsp_data_q;
    logic           start_a_q, rd_rq_q, wr_rq_q, adr_par_q, par_out_q, valid_out_a_q, adr_hold_q;
    logic [3:0]     rq_q;
    logic [21:0]    adr_q;
    logic [35:0]    d_out_q;

    logic [1:0]     word_first_d, word_next_d;
    logic [35:0]    cur_word_d;

    assign word_first_d = next_set(cmd_mask_i, cmd_adr_i[1:0], 1'b1);
    assign word_next_d  = next_set(mask_q, word_q, 1'b0);
    assign cur_word_d   = word_sel(wdata_q, word_q);

    // Single-process FSM; every MBUS and response output comes straight from a flop.
    always_ff @(posedge clk_i) begin
        if (!reset_l_i) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b1;
            write_q       <= 1'b0;
            mask_q        <= 4'd0;
            wdata_q       <= 144'd0;
            word_q        <= 2'd0;
            cnt_q         <= 3'd0;
            timer_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_par_err_q <= 1'b0;
            rsp_word_q    <= 2'd0;
            rsp_data_q    <= 36'd0;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            start_a_q     <= 1'b0;
            rd_rq_q       <= 1'b0;
            wr_rq_q       <= 1'b0;
            rq_q          <= 4'd0;
            adr_q         <= 22'd0;
            adr_par_q     <= 1'b0;
            d_out_q       <= 36'd0;
            par_out_q     <= 1'b0;
            valid_out_a_q <= 1'b0;
            adr_hold_q    <= 1'b0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_par_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        cmd_ready_q <= 1'b0;
                        write_q     <= cmd_write_i;
                        mask_q      <= cmd_mask_i;
                        wdata_q     <= cmd_wdata_i;
                        word_q      <= word_first_d;
                        cnt_q       <= popcnt4(cmd_mask_i);
                        timer_q     <= '0;
                        if (cmd_mask_i == 4'd0) begin
                            state_q       <= S_DONE;
                            done_q        <= 1'b1;
                            err_timeout_q <= 1'b0;
                        end else begin
                            state_q    <= S_START;
                            start_a_q  <= 1'b1;
                            rd_rq_q    <= ~cmd_write_i;
                            wr_rq_q    <= cmd_write_i;
                            rq_q       <= cmd_mask_i;
                            adr_q      <= cmd_adr_i;
                            adr_par_q  <= odd_par22(cmd_adr_i);
                            adr_hold_q <= 1'b1;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_START: begin
                    // ACKN takes priority over a timeout expiring on the same edge.
                    if (mbus_ackn_a_i) begin
                        start_a_q <= 1'b0;
                        rd_rq_q   <= 1'b0;
                        wr_rq_q   <= 1'b0;
                        timer_q   <= '0;
                        if (write_q) begin
                            state_q       <= S_WDATA;
                            valid_out_a_q <= 1'b1;
                            d_out_q       <= cur_word_d;
                            par_out_q     <= odd_par36(cur_word_d);
                            word_q        <= word_next_d;
                            cnt_q         <= cnt_q - 3'd1;
                        end else begin
                            state_q <= S_RDATA;
                        end
                    end else if (timer_q == ACK_LAST) begin
                        state_q       <= S_DONE;
                        done_q        <= 1'b1;
                        err_timeout_q <= 1'b1;
                        start_a_q     <= 1'b0;
                        rd_rq_q       <= 1'b0;
                        wr_rq_q       <= 1'b0;
                        adr_hold_q    <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_WDATA: begin
                    if (cnt_q == 3'd0) begin
                        state_q       <= S_DONE;
                        done_q        <= 1'b1;
                        valid_out_a_q <= 1'b0;
                        d_out_q       <= 36'd0;
                        par_out_q     <= 1'b0;
                        adr_hold_q    <= 1'b0;
                    end else begin
                        valid_out_a_q <= 1'b1;
                        d_out_q       <= cur_word_d;
                        par_out_q     <= odd_par36(cur_word_d);
                        word_q        <= word_next_d;
                        cnt_q         <= cnt_q - 3'd1;
                    end
                end
                S_RDATA: begin
                    // The last word is presented first; done follows one cycle later.
                    if (cnt_q == 3'd0) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        adr_hold_q <= 1'b0;
                    end else if (mbus_valid_in_a_i) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_word_q    <= word_q;
                        rsp_data_q    <= mbus_d_in_i;
                        rsp_par_err_q <= ~(^{mbus_d_in_i, mbus_par_in_i});
                        word_q        <= word_next_d;
                        cnt_q         <= cnt_q - 3'd1;
                        timer_q       <= '0;
                    end else if (timer_q == DATA_LAST) begin
                        state_q       <= S_DONE;
                        done_q        <= 1'b1;
                        err_timeout_q <= 1'b1;
                        adr_hold_q    <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q       <= S_IDLE;
                    cmd_ready_q   <= 1'b1;
                    done_q        <= 1'b0;
                    err_timeout_q <= 1'b0;
                    rq_q          <= 4'd0;
                    adr_q         <= 22'd0;
                    adr_par_q     <= 1'b0;
                    adr_hold_q    <= 1'b0;
                end
                default: begin
                    state_q       <= S_IDLE;
                    cmd_ready_q   <= 1'b1;
                    done_q        <= 1'b0;
                    err_timeout_q <= 1'b0;
                    start_a_q     <= 1'b0;
                    valid_out_a_q <= 1'b0;
                    adr_hold_q    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o        = cmd_ready_q;
    assign rsp_valid_o        = rsp_valid_q;
    assign rsp_word_o         = rsp_word_q;
    assign rsp_data_o         = rsp_data_q;
    assign rsp_par_err_o      = rsp_par_err_q;
    assign done_o             = done_q;
    assign err_timeout_o      = err_timeout_q;
    assign mbus_clk_o         = clk_i;
    assign mbus_start_a_o     = start_a_q;
    assign mbus_start_b_o     = 1'b0;
    assign mbus_rd_rq_o       = rd_rq_q;
    assign mbus_wr_rq_o       = wr_rq_q;
    assign mbus_rq_o          = rq_q;
    assign mbus_adr_o         = adr_q;
    assign mbus_adr_par_o     = adr_par_q;
    assign mbus_d_out_o       = d_out_q;
    assign mbus_par_out_o     = par_out_q;
    assign mbus_valid_out_a_o = valid_out_a_q;
    assign mbus_valid_out_b_o = 1'b0;
    assign mbus_adr_hold_o    = adr_hold_q;
    assign mbus_mem_reset_o   = 1'b0;
    assign mbus_diag_o        = 1'b0;

endmodule

// File: tb/tb_mbus_requester.sv
// Bench for mbus_requester: a table of commands plus random traffic, served by a
// behavioural MB20 memory model that also predicts word order, data and timing.
module tb_mbus_requester;

    localparam int ACK_TO  = 8;
    localparam int DATA_TO = 8;

    logic         clk = 1'b0;
    logic         reset_l_i, cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [21:0]  cmd_adr_i;
    logic [3:0]   cmd_mask_i;
    logic [143:0] cmd_wdata_i;
    logic         rsp_valid_o, rsp_par_err_o, done_o, err_timeout_o;
    logic [1:0]   rsp_word_o;
    logic [35:0]  rsp_data_o;
    logic         mbus_clk_o, mbus_start_a_o, mbus_start_b_o, mbus_rd_rq_o, mbus_wr_rq_o;
    logic [3:0]   mbus_rq_o;
    logic [21:0]  mbus_adr_o;
    logic         mbus_adr_par_o, mbus_par_out_o, mbus_valid_out_a_o, mbus_valid_out_b_o;
    logic [35:0]  mbus_d_out_o;
    logic         mbus_adr_hold_o, mbus_mem_reset_o, mbus_diag_o;
    logic         mbus_ackn_a_i, mbus_valid_in_a_i, mbus_par_in_i;
    logic [35:0]  mbus_d_in_i;

    int n_checks = 0;
    int n_err    = 0;

    logic [35:0] mem [logic [21:0]];

    typedef struct packed {
        logic         wr;
        logic [21:0]  adr;
        logic [0:3]   rq;
        logic [0:143] wd;
        logic [3:0]   ack_delay;
        logic         no_ack;
        logic [2:0]   corrupt;      // word with bad parity, 4 = none
        logic [2:0]   stall_after;  // memory supplies at most this many words
        logic [2:0]   rst_after;    // reset after this many write words, 0 = never
        logic [1:0]   gap_max;
        logic [2:0]   exp_n;
        logic         exp_to;
        logic [2:0]   exp_first;    // first read word index, 4 = unchecked
    } vec_t;

    mbus_requester #(.ACK_TIMEOUT(ACK_TO), .DATA_TIMEOUT(DATA_TO)) dut (
        .clk_i(clk), .reset_l_i(reset_l_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_adr_i(cmd_adr_i), .cmd_mask_i(cmd_mask_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_word_o(rsp_word_o), .rsp_data_o(rsp_data_o),
        .rsp_par_err_o(rsp_par_err_o), .done_o(done_o), .err_timeout_o(err_timeout_o),
        .mbus_clk_o(mbus_clk_o), .mbus_start_a_o(mbus_start_a_o), .mbus_start_b_o(mbus_start_b_o),
        .mbus_rd_rq_o(mbus_rd_rq_o), .mbus_wr_rq_o(mbus_wr_rq_o), .mbus_rq_o(mbus_rq_o),
        .mbus_adr_o(mbus_adr_o), .mbus_adr_par_o(mbus_adr_par_o), .mbus_d_out_o(mbus_d_out_o),
        .mbus_par_out_o(mbus_par_out_o), .mbus_valid_out_a_o(mbus_valid_out_a_o),
        .mbus_valid_out_b_o(mbus_valid_out_b_o), .mbus_adr_hold_o(mbus_adr_hold_o),
        .mbus_mem_reset_o(mbus_mem_reset_o), .mbus_diag_o(mbus_diag_o),
        .mbus_ackn_a_i(mbus_ackn_a_i), .mbus_valid_in_a_i(mbus_valid_in_a_i),
        .mbus_d_in_i(mbus_d_in_i), .mbus_par_in_i(mbus_par_in_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] mem_rd(input logic [21:0] adr, input int w);
        logic [21:0] key;
        key = {adr[21:2], 2'(w)};
        if (mem.exists(key)) return mem[key];
        return {key, 14'h1A5};
    endfunction

    function automatic vec_t mk(input logic wr, input logic [21:0] adr, input logic [0:3] rq,
                                input logic [0:143] wd, input int dly, input logic no_ack,
                                input int corrupt, input int stall, input int rst, input int gap,
                                input int exp_n, input logic exp_to, input int exp_first);
        vec_t v;
        v.wr = wr; v.adr = adr; v.rq = rq; v.wd = wd; v.ack_delay = 4'(dly);
        v.no_ack = no_ack; v.corrupt = 3'(corrupt); v.stall_after = 3'(stall);
        v.rst_after = 3'(rst); v.gap_max = 2'(gap); v.exp_n = 3'(exp_n);
        v.exp_to = exp_to; v.exp_first = 3'(exp_first);
        return v;
    endfunction

    task automatic idle_inputs();
        cmd_valid_i = 1'b0; mbus_ackn_a_i = 1'b0; mbus_valid_in_a_i = 1'b0;
        mbus_d_in_i = 36'd0; mbus_par_in_i = 1'b0;
    endtask

    task automatic run_cmd(input vec_t v, input logic junk);
        int order[$];
        int exp_w[$];
        logic [35:0] exp_d[$];
        logic exp_pe[$];
        int w, n, sent, gap, ack_cnt, ack_cyc, start_cyc, last_start, nvalid, first_valid;
        int last_valid, nrsp, first_rsp, last_rsp, done_cyc;
        logic acked, seen_start, to_seen, hold_seen;
        logic [35:0] wd;

        for (int i = 0; i < 4; i++) begin
            w = (int'(v.adr[1:0]) + i) % 4;
            if (v.rq[w]) order.push_back(w);
        end
        n = 0;
        while (cmd_ready_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("cmd_ready_idle", cmd_ready_o, 1);
        cmd_valid_i = 1'b1; cmd_write_i = v.wr; cmd_adr_i = v.adr;
        cmd_mask_i = v.rq; cmd_wdata_i = v.wd;
        acked = 1'b0; seen_start = 1'b0; to_seen = 1'b0; hold_seen = 1'b1;
        sent = 0; gap = 0; ack_cnt = 0; ack_cyc = -1; start_cyc = 0; last_start = -1;
        nvalid = 0; first_valid = -1; last_valid = -1; nrsp = 0; first_rsp = -1;
        last_rsp = -1; done_cyc = -1;
        for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            idle_inputs();
            if (junk) begin
                cmd_valid_i = 1'($urandom_range(0, 1));
                cmd_adr_i = 22'($urandom); cmd_mask_i = 4'($urandom); cmd_write_i = 1'($urandom);
            end
            if (cyc == 0) chk("accept_to_startA", mbus_start_a_o, order.size() != 0);
            if (done_o) begin
                done_cyc = cyc; to_seen = err_timeout_o; hold_seen = mbus_adr_hold_o;
                cmd_valid_i = 1'b0;
            end
            if (mbus_start_a_o) begin
                if (!seen_start) begin
                    seen_start = 1'b1;
                    chk("mbus_adr", mbus_adr_o, v.adr);
                    chk("mbus_rq", mbus_rq_o, v.rq);
                    chk("mbus_rdRq", mbus_rd_rq_o, !v.wr);
                    chk("mbus_wrRq", mbus_wr_rq_o, v.wr);
                    chk("mbus_adrPar", mbus_adr_par_o, ~^v.adr);
                    chk("mbus_adrHold", mbus_adr_hold_o, 1);
                end
                start_cyc++; last_start = cyc;
                if (!v.no_ack && ack_cnt == int'(v.ack_delay)) begin
                    mbus_ackn_a_i = 1'b1; acked = 1'b1; ack_cyc = cyc;
                end else begin
                    ack_cnt++;
                end
            end
            if (mbus_valid_out_a_o) begin
                if (first_valid < 0) first_valid = cyc;
                last_valid = cyc;
                if (nvalid < order.size()) begin
                    w = order[nvalid];
                    wd = v.wd[w*36 +: 36];
                    chk("wr_dOut", mbus_d_out_o, wd);
                    chk("wr_parOut", mbus_par_out_o, ~^wd);
                    mem[{v.adr[21:2], 2'(w)}] = wd;
                end else begin
                    chk("wr_unexpected_word", mbus_valid_out_a_o, 0);
                end
                nvalid++;
                if (v.rst_after != 3'd0 && nvalid == int'(v.rst_after)) begin
                    reset_l_i = 1'b0;
                    cmd_valid_i = 1'b0;
                    @(negedge clk);
                    chk("rst_startA", mbus_start_a_o, 0);
                    chk("rst_validOutA", mbus_valid_out_a_o, 0);
                    chk("rst_adrHold", mbus_adr_hold_o, 0);
                    chk("rst_no_done", done_o, 0);
                    chk("rst_cmd_ready", cmd_ready_o, 1);
                    reset_l_i = 1'b1;
                    return;
                end
            end
            if (rsp_valid_o) begin
                if (first_rsp < 0) first_rsp = int'(rsp_word_o);
                last_rsp = cyc;
                if (exp_w.size() > 0) begin
                    chk("rsp_word", rsp_word_o, exp_w.pop_front());
                    chk("rsp_data", rsp_data_o, exp_d.pop_front());
                    chk("rsp_par_err", rsp_par_err_o, exp_pe.pop_front());
                end else begin
                    chk("rsp_unexpected", rsp_valid_o, 0);
                end
                nrsp++;
            end
            // Memory side of a read: one word per cycle with random gaps, after ACKN.
            if (!v.wr && acked && cyc > ack_cyc && done_cyc < 0 &&
                sent < order.size() && sent < int'(v.stall_after)) begin
                if (gap == 0) begin
                    w = order[sent];
                    wd = mem_rd(v.adr, w);
                    mbus_valid_in_a_i = 1'b1;
                    mbus_d_in_i = wd;
                    mbus_par_in_i = (~^wd) ^ (w == int'(v.corrupt));
                    exp_w.push_back(w); exp_d.push_back(wd); exp_pe.push_back(w == int'(v.corrupt));
                    sent++;
                    gap = $urandom_range(0, int'(v.gap_max));
                end else begin
                    gap--;
                end
            end
        end
        chk("done_seen", done_cyc >= 0, 1);
        chk("err_timeout", to_seen, v.exp_to);
        chk("adrHold_low_at_done", hold_seen, 0);
        if (v.wr) chk("wr_word_count", nvalid, v.exp_n);
        else      chk("rd_word_count", nrsp, v.exp_n);
        chk("startA_cycles", start_cyc,
            v.no_ack ? ACK_TO : (order.size() != 0 ? int'(v.ack_delay) + 1 : 0));
        if (v.wr && nvalid > 0) begin
            chk("wr_first_after_ack", first_valid, ack_cyc + 1);
            chk("done_after_last_wr", done_cyc, last_valid + 1);
        end
        if (!v.wr && !v.exp_to && nrsp > 0) chk("done_after_last_rsp", done_cyc, last_rsp + 1);
        if (!v.wr && v.exp_first < 3'd4 && nrsp > 0) chk("rd_first_word", first_rsp, v.exp_first);
        if (v.no_ack) chk("done_after_startA", done_cyc, last_start + 1);
        if (order.size() == 0) chk("zero_mask_done_next", done_cyc, 0);
        @(negedge clk);
        idle_inputs();
        chk("done_one_cycle", done_o, 0);
        chk("ready_after_done", cmd_ready_o, 1);
    endtask

    vec_t vecs [12];
    vec_t rv;

    initial begin
        vecs[0]  = mk(1'b1, 22'o1000, 4'b1111, {36'd1, 36'd2, 36'd3, 36'd4}, 1, 1'b0, 4, 4, 0, 0, 4, 1'b0, 4);
        vecs[1]  = mk(1'b0, 22'o1000, 4'b1111, 144'd0, 2, 1'b0, 4, 4, 0, 1, 4, 1'b0, 0);
        vecs[2]  = mk(1'b0, 22'o1002, 4'b1011, 144'd0, 0, 1'b0, 4, 4, 0, 0, 3, 1'b0, 2);
        vecs[3]  = mk(1'b1, 22'o1000, 4'b0000, 144'd0, 0, 1'b0, 4, 4, 0, 0, 0, 1'b0, 4);
        vecs[4]  = mk(1'b0, 22'o1000, 4'b1111, 144'd0, 0, 1'b1, 4, 4, 0, 0, 0, 1'b1, 4);
        vecs[5]  = mk(1'b0, 22'o1000, 4'b1111, 144'd0, 1, 1'b0, 1, 4, 0, 2, 4, 1'b0, 0);
        vecs[6]  = mk(1'b1, 22'o2003, 4'b0110, {36'hA, 36'hB, 36'hC, 36'hD}, 3, 1'b0, 4, 4, 0, 0, 2, 1'b0, 4);
        vecs[7]  = mk(1'b0, 22'o2003, 4'b1111, 144'd0, 0, 1'b0, 4, 1, 0, 0, 1, 1'b1, 3);
        vecs[8]  = mk(1'b1, 22'o3000, 4'b1111, {36'h5, 36'h6, 36'h7, 36'h8}, 0, 1'b0, 4, 4, 2, 0, 4, 1'b0, 4);
        vecs[9]  = mk(1'b1, 22'o3001, 4'b1101, {36'h11, 36'h22, 36'h33, 36'h44}, 1, 1'b0, 4, 4, 0, 0, 3, 1'b0, 4);
        vecs[10] = mk(1'b0, 22'o3001, 4'b1101, 144'd0, 0, 1'b0, 4, 4, 0, 1, 3, 1'b0, 1);
        vecs[11] = mk(1'b1, 22'o4000, 4'b1000, {36'h77, 108'd0}, 7, 1'b0, 4, 4, 0, 0, 1, 1'b0, 4);

        reset_l_i = 1'b0; cmd_write_i = 1'b0; cmd_adr_i = 22'd0; cmd_mask_i = 4'd0;
        cmd_wdata_i = 144'd0; idle_inputs();
        repeat (2) @(negedge clk);
        chk("reset_cmd_ready", cmd_ready_o, 1);
        chk("reset_done", done_o, 0);
        chk("reset_err_timeout", err_timeout_o, 0);
        chk("reset_startA", mbus_start_a_o, 0);
        chk("reset_adrHold", mbus_adr_hold_o, 0);
        chk("reset_validOutA", mbus_valid_out_a_o, 0);
        chk("reset_rsp_valid", rsp_valid_o, 0);
        chk("fixed_outputs", {mbus_start_b_o, mbus_valid_out_b_o, mbus_mem_reset_o, mbus_diag_o}, 0);
        reset_l_i = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_cmd(vecs[i], 1'b0);

        for (int i = 0; i < 40; i++) begin
            rv = mk(1'($urandom_range(0, 1)), {12'd0, 10'($urandom_range(0, 1023))}, 4'($urandom),
                    {$urandom, $urandom, $urandom, $urandom, 16'($urandom)},
                    $urandom_range(0, 4), 1'b0, $urandom_range(0, 4), 4, 0, $urandom_range(0, 3),
                    0, 1'b0, 4);
            rv.exp_n = 3'($countones(rv.rq));
            run_cmd(rv, 1'b1);
        end
        chk("fixed_outputs_end", {mbus_start_b_o, mbus_valid_out_b_o, mbus_mem_reset_o, mbus_diag_o}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/mbus_requester.md
# mbus_requester

Bus-initiator end of the MBUS memory-port protocol: a standalone requester that issues quadword read and write cycles to an MB20 memory over the `iMBUS` mbox modport, standing in for the KL10 MBOX. It gives the front-end simulator and benches a direct path to preload, dump and check memory without running the cache or MBOX. It runs port A only and reports ACKN timeouts and read-parity errors.

## Interface

Parameters:
- `ACK_TIMEOUT`, 64: cycles to wait for `acknA` after `startA` before aborting with a timeout.
- `DATA_TIMEOUT`, 64: cycles to wait for each `validInA` word on a read before aborting with a timeout.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset_l`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  a command is offered.
- `cmd_ready`  out  1  block is idle and will accept a command this cycle.
- `cmd_write`  in  1  1 selects write, 0 selects read.
- `cmd_adr`  in  22  word address [14:35]; bits [34:35] give the starting word.
- `cmd_mask`  in  4  `rq[0:3]`, words of the quad to transfer.
- `cmd_wdata`  in  144  four write words, word0 in bits [0:35].
- `rsp_valid`  out  1  one read word is presented.
- `rsp_word`  out  2  index of the presented word.
- `rsp_data`  out  36  read data.
- `rsp_par_err`  out  1  odd-parity check failed on this word.
- `done`  out  1  one-cycle pulse when the command completes.
- `err_timeout`  out  1  qualifies `done`; the command aborted on a timeout.
- `mbus`  modport `iMBUS.mbox`: drives `startA`, `startB`, `rdRq`, `wrRq`, `rq`, `adr`, `adrPar`, `dOut`, `parOut`, `validOutA`, `validOutB`, `adrHold`, `memReset`, `diag` and `clk`; receives `acknA`, `validInA`, `dIn` and `parIn`.

## Operation

- States: IDLE, START, RDATA, WDATA, DONE.
- IDLE:
  - `cmd_ready`=1.
  - When `cmd_valid` is 1, latch the command and go to START.
  - If `cmd_mask`=0, go directly to DONE and generate no MBUS activity.
- START:
  - Drive `startA`=1, `rdRq`=!write, `wrRq`=write, `rq`=mask, `adr`=cmd_adr, `adrPar`=~^adr (odd parity), `adrHold`=1.
  - Hold all of these until `acknA` is sampled 1.
  - On `acknA`, drop `startA` and go to RDATA or WDATA.
  - If `ACK_TIMEOUT` cycles pass without `acknA`, go to DONE with a timeout.
- Word order:
  - Start at adr[34:35] and increment mod 4.
  - Visit only words whose mask bit is set.
  - The number of words equals the popcount of the mask.
- WDATA:
  - Each cycle, drive `validOutA`=1, `dOut` = the current word, `parOut`=~^dOut.
  - Advance to the next word every cycle.
  - After the last word, go to DONE.
- RDATA:
  - On each cycle with `validInA`=1, present the data next cycle on `rsp_valid`/`rsp_word`/`rsp_data`.
  - Set `rsp_par_err` = (^{dIn,parIn} == 0).
  - After the last word, go to DONE.
  - The per-word timeout restarts after every received word.
- DONE:
  - `done`=1 for one cycle; `err_timeout` is valid with it.
  - `adrHold` drops; return to IDLE.
- Fixed outputs: `startB`, `validOutB`, `memReset` and `diag` are always 0. `mbus.clk` = `clk`.
- Parity errors are reported only; they do not abort the command.

## Timing

- Reset (`reset_l`=0 at a clk edge):
  - All outputs go to 0 except `cmd_ready`, which goes to 1.
  - State returns to IDLE and timeout counters clear.
- Reset in the middle of a command:
  - The command is abandoned with no `done` pulse.
  - MBUS strobes deassert on the same edge.
- Accept to `startA`: 1 cycle, because every MBUS output is registered.
- `acknA` sampled at edge N: `startA`=0 from N+1. The first write word (`validOutA`) is driven from N+1.
- Write length: exactly popcount(mask) consecutive `validOutA` cycles with no gaps. `done` follows the last word by one cycle.
- Read data: `validInA` at edge N produces `rsp_valid` at N+1. `done` comes the cycle after the last `rsp_valid`.
- Timeouts:
  - The counter increments in START, and in RDATA while waiting.
  - When it reaches the parameter value, `done` and `err_timeout` assert on the next cycle.
- `validInA` outside RDATA is ignored.
- `acknA` and timeout expiry in the same cycle: `acknA` wins.
- `cmd_valid` while not ready is ignored, and the command is not latched.

## Test plan

- Write quad, then read back:
  - Stimulus: write adr=0o1000, mask=1111, words 1,2,3,4, then a read of the same quad.
  - Required: four `validOutA` cycles with `parOut` correct; the read gives rsp_word 0..3 with data 1..4, `rsp_par_err`=0, and `done` without timeout.
- Wrapped partial read:
  - Stimulus: adr[34:35]=2, mask=1011.
  - Required: `rsp_word` sequence 2, 3, 0; exactly three `rsp_valid`.
- Zero mask:
  - Stimulus: a command with mask=0000.
  - Required: `done` the next cycle, `startA` never asserts, `err_timeout`=0.
- ACKN timeout:
  - Stimulus: a memory model that never asserts `acknA`, with ACK_TIMEOUT=8.
  - Required: `startA` high for 8 cycles, then `done`=1 with `err_timeout`=1, and `adrHold` low afterwards.
- Parity error:
  - Stimulus: corrupt `parIn` on word 1 of a full read.
  - Required: `rsp_par_err`=1 only on word 1; all four words are still delivered.
- Reset in the middle of a write:
  - Stimulus: drop `reset_l` after the second `validOutA`.
  - Required: all strobes are 0 the next cycle, no `done`, `cmd_ready`=1, and a following command completes normally.
